sc_fir_tap_eval: RTL and testbench
==================================

// Module: sc_fir_tap_eval
// PURPOSE
//  Stochastic-computing FIR evaluator. Sits directly downstream of the 39-tap input delay line.
//  On start, snapshots the 39 binary tap values and 39 coefficients.
//  Converts each value to a unipolar bitstream, multiplies tap by coefficient with an AND gate,
//  then popcounts and accumulates over 2^LEN_LOG2 cycles.
//  Returns one binary FIR sample per start with a done pulse; feeds the output scaling stage.
// PARAMETERS
//  WIDTH     8      bit width of tap and coefficient values (unsigned, unipolar)
//  TAPS      39     number of taps / coefficients
//  LEN_LOG2  8      stream length = 2^LEN_LOG2 cycles per evaluation
//  SEED_X    8'h5A  reload seed of tap-stream LFSR (nonzero)
//  SEED_C    8'hC3  reload seed of coefficient-stream LFSR (nonzero)
// PORTS
//  clock  in   1                single clock, rising edge
//  reset  in   1                asynchronous, active-high
//  start  in   1                request evaluation; accepted only in IDLE
//  taps   in   WIDTH x TAPS     unpacked [TAPS-1:0]; sampled on accepted start
//  coef   in   WIDTH x TAPS     unpacked [TAPS-1:0]; sampled on accepted start
//  busy   out  1                high in RUN
//  done   out  1                one-cycle pulse when y becomes valid
//  y      out  LEN_LOG2+6       accumulated product count; held until next accepted start
// BEHAVIOUR
//  Reset: async, active-high. FSM=IDLE, busy=0, done=0, y=0, acc=0, cnt=0.
//   Snapshot regs=0. LFSRs=SEED_X/SEED_C.
//  FSM IDLE -> RUN on start. RUN -> DONE when cnt==2^LEN_LOG2-1 (after that cycle's accumulate).
//   DONE -> IDLE unconditionally (1 cycle).
//  Accept (IDLE & start):
//   - latch taps/coef into snapshot regs
//   - acc<=0, cnt<=0
//   - LFSRs reload seeds, so results are reproducible per input set
//   - y holds the previous value
//  RUN, each cycle:
//   - LFSR_X, LFSR_C: WIDTH-bit maximal-length Fibonacci LFSRs, both advance every RUN cycle.
//     For WIDTH=8, taps x^8+x^6+x^5+x^4+1. State range 1..2^WIDTH-1.
//   - Stream bit for value v against LFSR state r: (v=={WIDTH{1'b1}}) ? 1 : (r < v).
//     v=0 gives constant 0; all-ones gives constant 1.
//   - All taps share LFSR_X; all coefs share LFSR_C. X and C are decorrelated by distinct seeds.
//   - prod[i] = xbit[i] & cbit[i]
//   - acc += popcount(prod[TAPS-1:0]); popcount is 0..39 (6 bits).
//   - cnt increments.
//  Widths: acc/y are LEN_LOG2+6 bits. Max 39*2^LEN_LOG2 = 9984 for defaults, so no overflow.
//  On the RUN->DONE transition: y<=final acc (including the last cycle's term), done=1 for exactly that
//   DONE cycle, busy=0.
//  Latency: accepted start at edge k gives done high in cycle k+2^LEN_LOG2+1, i.e. 257 cycles for defaults.
//  Start while RUN or DONE: ignored, no queueing. Start in the cycle after DONE (IDLE): accepted.
//  Input changes during RUN have no effect; only snapshots are used. The upstream delay line may keep shifting.
//  Reset mid-RUN: immediate return to IDLE, y=0, no done pulse.
//  start held high continuously: back-to-back evaluations, one every 2^LEN_LOG2+2 cycles.
// TESTING
//  1 All taps=8'hFF, all coef=8'hFF, pulse start
//    -> done 257 cycles later, y=39*256=9984, busy high exactly 256 cycles.
//  2 All taps=0, coef=8'hFF -> y=0. Then taps[0]=8'hFF, coef[0]=8'hFF, others 0 -> y=256.
//  3 taps[5]=8'h80, coef[5]=8'hFF, others 0
//    -> y equals the count of LFSR_X states <128 over 256 cycles from SEED_X (model check), within 128±16.
//  4 Change taps/coef every cycle during RUN after a start with case-1 values
//    -> y still 9984. Start pulses during RUN produce no extra done.
//  5 Assert reset asynchronously at cycle 100 of RUN
//    -> busy, done, y drop to 0 at once. A fresh start afterwards gives a result identical to an uninterrupted run.
//  6 Hold start=1 for 1000 cycles with case-1 values
//    -> done pulses spaced 258 cycles apart, y=9984 each time.

Source files
------------

// File: rtl/sc_fir_tap_eval.sv
// sc_fir_tap_eval: stochastic-computing FIR evaluator.
// Snapshots the tap and coefficient vectors on an accepted start, turns each value into
// a unipolar bitstream by comparing it against a shared LFSR, multiplies tap by coefficient
// with an AND gate and accumulates the popcount of all products over 2^LEN_LOG2 cycles.
module sc_fir_tap_eval #(
    parameter int              WIDTH    = 8,
    parameter int              TAPS     = 39,
    parameter int              LEN_LOG2 = 8,
    parameter logic [WIDTH-1:0] SEED_X  = 8'h5A,
    parameter logic [WIDTH-1:0] SEED_C  = 8'hC3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      taps [TAPS-1:0],
    input  logic [WIDTH-1:0]      coef [TAPS-1:0],
    output logic                  busy,
    output logic                  done,
    output logic [LEN_LOG2+5:0]   y
);

    localparam int ACC_W = LEN_LOG2 + 6;
    localparam int POP_W = 6;

    // Feedback tap masks of maximal-length Fibonacci LFSRs, indexed by register width.
    // A set bit k means the term x^(k+1) participates in the feedback.
    function automatic logic [31:0] lfsrMaskFor(input int w);
        logic [31:0] m;
        case (w)
            3:       m = 32'h0000_0006;
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            12:      m = 32'h0000_0E08;
            16:      m = 32'h0000_D008;
            default: m = 32'h0000_00B8;
        endcase
        return m;
    endfunction

    localparam logic [WIDTH-1:0] LFSR_MASK = WIDTH'(lfsrMaskFor(WIDTH));
    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [WIDTH-1:0]      snap_taps [TAPS-1:0];
    logic [WIDTH-1:0]      snap_coef [TAPS-1:0];
    logic [WIDTH-1:0]      lfsr_x;
    logic [WIDTH-1:0]      lfsr_c;
    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      acc_next;
    logic [LEN_LOG2-1:0]   cnt;
    logic [TAPS-1:0]       xbit;
    logic [TAPS-1:0]       cbit;
    logic [TAPS-1:0]       prod;
    logic [POP_W-1:0]      pop;
    logic                  accept;
    logic                  last_cycle;

    assign accept     = (state == S_IDLE) && start;
    assign last_cycle = (state == S_RUN) && (cnt == {LEN_LOG2{1'b1}});

    // State register; reset drops straight back to IDLE even in the middle of a run.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs; DONE lasts exactly one cycle so done is a pulse.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt == {LEN_LOG2{1'b1}}) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Stream generation, AND-multiply and popcount of all tap products for this cycle.
    // All-ones values bypass the comparator because the LFSR never reaches all ones plus one.
    always_comb begin
        xbit = '0;
        cbit = '0;
        prod = '0;
        pop  = '0;
        for (int i = 0; i < TAPS; i++) begin
            xbit[i] = (snap_taps[i] == ALL_ONES) ? 1'b1 : (lfsr_x < snap_taps[i]);
            cbit[i] = (snap_coef[i] == ALL_ONES) ? 1'b1 : (lfsr_c < snap_coef[i]);
            prod[i] = xbit[i] & cbit[i];
            pop     = pop + POP_W'(prod[i]);
        end
        acc_next = acc + ACC_W'(pop);
    end

    // Snapshot of the inputs taken only on an accepted start; upstream may keep shifting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                snap_taps[i] <= '0;
                snap_coef[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < TAPS; i++) begin
                snap_taps[i] <= taps[i];
                snap_coef[i] <= coef[i];
            end
        end
    end

    // Both LFSRs reload their seeds on accept so each input set gives a reproducible result,
    // then step together every RUN cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_x <= SEED_X;
            lfsr_c <= SEED_C;
        end else if (accept) begin
            lfsr_x <= SEED_X;
            lfsr_c <= SEED_C;
        end else if (state == S_RUN) begin
            lfsr_x <= {lfsr_x[WIDTH-2:0], ^(lfsr_x & LFSR_MASK)};
            lfsr_c <= {lfsr_c[WIDTH-2:0], ^(lfsr_c & LFSR_MASK)};
        end
    end

    // Accumulator, cycle counter and result register; y picks up the final sum including
    // the last cycle's term and then holds until a later run completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
            y   <= '0;
        end else if (accept) begin
            acc <= '0;
            cnt <= '0;
        end else if (state == S_RUN) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (last_cycle) begin
                y <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_sc_fir_tap_eval.sv
// tb_sc_fir_tap_eval: directed self-checking bench for sc_fir_tap_eval.
module tb_sc_fir_tap_eval;

    localparam int WIDTH    = 8;
    localparam int TAPS     = 39;
    localparam int LEN_LOG2 = 8;

    logic                 clock;
    logic                 reset;
    logic                 start;
    logic [WIDTH-1:0]     taps [TAPS-1:0];
    logic [WIDTH-1:0]     coef [TAPS-1:0];
    logic                 busy;
    logic                 done;
    logic [LEN_LOG2+5:0]  y;

    int checks = 0;
    int errors = 0;

    sc_fir_tap_eval #(
        .WIDTH    (WIDTH),
        .TAPS     (TAPS),
        .LEN_LOG2 (LEN_LOG2),
        .SEED_X   (8'h5A),
        .SEED_C   (8'hC3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .taps  (taps),
        .coef  (coef),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    // 10 ns clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] tv, input logic [WIDTH-1:0] cv);
        for (int i = 0; i < TAPS; i++) begin
            taps[i] = tv;
            coef[i] = cv;
        end
    endtask

    // Raise start for exactly one rising edge
    task automatic pulseStart();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Counts negedges after the accepting edge until done; bounded
    task automatic waitDone(output int lat, output int busyCnt, output bit found);
        lat     = 0;
        busyCnt = 0;
        found   = 1'b0;
        while (!found && lat < 400) begin
            @(negedge clock);
            lat++;
            if (busy === 1'b1) busyCnt++;
            if (done === 1'b1) found = 1'b1;
        end
    endtask

    // Reference: a step of x^8+x^6+x^5+x^4+1 in Fibonacci form
    function automatic logic [7:0] lfsrStep(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Reference count of one tap/coef pair over a full 256-cycle evaluation
    function automatic int modelCount(input logic [7:0] tv, input logic [7:0] cv);
        logic [7:0] x;
        logic [7:0] c;
        int         n;
        x = 8'h5A;
        c = 8'hC3;
        n = 0;
        for (int k = 0; k < 256; k++) begin
            if (((tv == 8'hFF) || (x < tv)) && ((cv == 8'hFF) || (c < cv))) n++;
            x = lfsrStep(x);
            c = lfsrStep(c);
        end
        return n;
    endfunction

    initial begin
        int  lat;
        int  busyCnt;
        bit  found;
        int  doneCnt;
        int  doneAt [$];
        int  yAtDone;
        int  expModel;

        start = 1'b0;
        reset = 1'b1;
        applyStimulus(8'h00, 8'h00);
        repeat (3) @(negedge clock);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_y",    int'(y),    0);
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] case 1: all ones");
        applyStimulus(8'hFF, 8'hFF);
        pulseStart();
        waitDone(lat, busyCnt, found);
        checkOutput("c1_found",   int'(found), 1);
        checkOutput("c1_latency", lat,         257);
        checkOutput("c1_busy",    busyCnt,     256);
        checkOutput("c1_y",       int'(y),     9984);
        @(negedge clock);
        checkOutput("c1_done_pulse", int'(done), 0);
        checkOutput("c1_y_hold",     int'(y),    9984);

        $display("[TB] case 2: zero taps, then one full tap");
        applyStimulus(8'h00, 8'hFF);
        pulseStart();
        waitDone(lat, busyCnt, found);
        checkOutput("c2a_found", int'(found), 1);
        checkOutput("c2a_y",     int'(y),     0);
        applyStimulus(8'h00, 8'h00);
        taps[0] = 8'hFF;
        coef[0] = 8'hFF;
        pulseStart();
        waitDone(lat, busyCnt, found);
        checkOutput("c2b_y", int'(y), 256);

        $display("[TB] case 3: half-scale and mixed streams");
        applyStimulus(8'h00, 8'h00);
        taps[5] = 8'h80;
        coef[5] = 8'hFF;
        pulseStart();
        waitDone(lat, busyCnt, found);
        checkOutput("c3_half_tap", int'(y), 128);
        applyStimulus(8'h00, 8'h00);
        taps[20] = 8'h40;
        coef[20] = 8'hFF;
        pulseStart();
        waitDone(lat, busyCnt, found);
        checkOutput("c3_quarter_tap", int'(y), 63);
        applyStimulus(8'h00, 8'h00);
        taps[38] = 8'hFF;
        coef[38] = 8'h40;
        pulseStart();
        waitDone(lat, busyCnt, found);
        checkOutput("c3_quarter_coef", int'(y), 63);
        applyStimulus(8'h80, 8'hFF);
        pulseStart();
        waitDone(lat, busyCnt, found);
        checkOutput("c3_all_half", int'(y), 39 * 128);
        applyStimulus(8'h00, 8'h00);
        taps[7] = 8'h80;
        coef[7] = 8'h80;
        expModel = modelCount(8'h80, 8'h80);
        pulseStart();
        waitDone(lat, busyCnt, found);
        checkOutput("c3_model_pair", int'(y), expModel);

        $display("[TB] case 4: input churn and start pulses during RUN");
        applyStimulus(8'hFF, 8'hFF);
        pulseStart();
        doneCnt = 0;
        yAtDone = -1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                doneCnt++;
                yAtDone = int'(y);
            end
            if (n < 200) begin
                for (int i = 0; i < TAPS; i++) begin
                    taps[i] = WIDTH'($urandom_range(0, 255));
                    coef[i] = WIDTH'($urandom_range(0, 255));
                end
                start = ((n % 7) == 3);
            end else begin
                start = 1'b0;
            end
        end
        checkOutput("c4_done_count", doneCnt, 1);
        checkOutput("c4_y",          yAtDone, 9984);

        $display("[TB] case 5: reset in the middle of RUN");
        applyStimulus(8'h00, 8'h00);
        taps[7] = 8'h80;
        coef[7] = 8'h80;
        pulseStart();
        repeat (100) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checkOutput("c5_busy_drop", int'(busy), 0);
        checkOutput("c5_done_drop", int'(done), 0);
        checkOutput("c5_y_drop",    int'(y),    0);
        @(negedge clock);
        reset = 1'b0;
        pulseStart();
        waitDone(lat, busyCnt, found);
        checkOutput("c5_latency", lat,     257);
        checkOutput("c5_rerun_y", int'(y), expModel);

        $display("[TB] case 6: start held high");
        applyStimulus(8'hFF, 8'hFF);
        @(negedge clock);
        start = 1'b1;
        for (int n = 1; n <= 1000; n++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                doneAt.push_back(n);
                checkOutput("c6_y", int'(y), 9984);
            end
        end
        start = 1'b0;
        checkOutput("c6_done_count", doneAt.size(), 3);
        if (doneAt.size() >= 1) checkOutput("c6_first_done", doneAt[0], 257);
        for (int k = 1; k < doneAt.size(); k++) begin
            checkOutput("c6_spacing", doneAt[k] - doneAt[k-1], 258);
        end
        repeat (300) @(negedge clock);
        checkOutput("c6_idle_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
